text_buffer_arbiter: RTL and testbench

Owns the write port of the shared 1024x8 character RAM, organised as 16 lines x 64 columns, and the text cursor. It serialises edit commands from two requesters: the PS/2 keyboard decoder and the CPU MMIO path. Round-robin arbitration decides between them. The display reads the RAM on its own port; this block never stalls display reads.

---
 rtl/text_buffer_arbiter.sv | 160 ++++++++++++++++
 tb/tb_text_buffer_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_arbiter.sv
// Round-robin arbiter that serialises keyboard and CPU edit commands onto the text RAM write port and owns the cursor.
// Optional build macro TB_ARB_BS_GUARD_EN stops backspace from crossing a line start.
module text_buffer_arbiter #(
  parameter int ADDR_W = 10,
  parameter int COL_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kbd_req,
  input  logic [1:0]        kbd_op,
  input  logic [DATA_W-1:0] kbd_char,
  output logic              kbd_ack,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_op,
  input  logic [DATA_W-1:0] cpu_char,
  output logic              cpu_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  localparam logic [1:0] OP_PUT   = 2'b00;
  localparam logic [1:0] OP_NL    = 2'b01;
  localparam logic [1:0] OP_BS    = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0]       ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0]       LAST_ADDR = '1;
  localparam logic [ADDR_W-COL_W-1:0] LINE_ONE  = 1;

  state_t            state;
  logic              last_grant;   // 1 = CPU was granted most recently
  logic              winner;       // 1 = CPU owns the command in flight
  logic [1:0]        op_reg;

  logic              kbd_win;
  logic              any_req;
  logic [1:0]        grant_op;
  logic [DATA_W-1:0] grant_char;
  logic              bs_ok;
  logic [ADDR_W-1:0] cursor_inc;
  logic [ADDR_W-1:0] cursor_dec;
  logic [ADDR_W-1:0] cursor_nl;

  // Keyboard wins when alone, or on a tie when the CPU had the last grant.
  assign kbd_win    = kbd_req && (!cpu_req || last_grant);
  assign any_req    = kbd_req || cpu_req;
  assign grant_op   = kbd_win ? kbd_op : cpu_op;
  assign grant_char = kbd_win ? kbd_char : cpu_char;

  assign cursor_inc = cursor + ADDR_ONE;
  assign cursor_dec = cursor - ADDR_ONE;
  assign cursor_nl  = {cursor[ADDR_W-1:COL_W] + LINE_ONE, {COL_W{1'b0}}};

`ifdef TB_ARB_BS_GUARD_EN
  assign bs_ok = (cursor[COL_W-1:0] != '0);
`else
  assign bs_ok = (cursor != '0);
`endif

  // Cursor is stable between the grant and the EXEC cycle, so bs_ok holds in both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cursor     <= '0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      op_reg     <= OP_PUT;
      kbd_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          kbd_ack <= 1'b0;
          cpu_ack <= 1'b0;
          ram_we  <= 1'b0;
          if (any_req) begin
            winner     <= !kbd_win;
            last_grant <= !kbd_win;
            op_reg     <= grant_op;
            busy       <= 1'b1;
            if (grant_op == OP_CLEAR) begin
              state     <= CLEAR;
              ram_we    <= 1'b1;
              ram_waddr <= '0;
              ram_wdata <= '0;
            end else begin
              state   <= EXEC;
              kbd_ack <= kbd_win;
              cpu_ack <= !kbd_win;
              case (grant_op)
                OP_PUT: begin
                  ram_we    <= 1'b1;
                  ram_waddr <= cursor;
                  ram_wdata <= grant_char;
                end
                OP_BS: begin
                  ram_we    <= bs_ok;
                  ram_waddr <= cursor_dec;
                  ram_wdata <= '0;
                end
                default: ram_we <= 1'b0;
              endcase
            end
          end
        end

        EXEC: begin
          state   <= IDLE;
          busy    <= 1'b0;
          kbd_ack <= 1'b0;
          cpu_ack <= 1'b0;
          ram_we  <= 1'b0;
          case (op_reg)
            OP_PUT: cursor <= cursor_inc;
            OP_NL:  cursor <= cursor_nl;
            OP_BS:  if (bs_ok) cursor <= cursor_dec;
            default: cursor <= cursor;
          endcase
        end

        CLEAR: begin
          if (ram_waddr == LAST_ADDR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ram_we  <= 1'b0;
            kbd_ack <= 1'b0;
            cpu_ack <= 1'b0;
            cursor  <= '0;
          end else begin
            ram_waddr <= ram_waddr + ADDR_ONE;
            // Ack is registered so it lands with the final address write.
            if (ram_waddr == LAST_ADDR - ADDR_ONE) begin
              kbd_ack <= !winner;
              cpu_ack <= winner;
            end
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ram_we  <= 1'b0;
          kbd_ack <= 1'b0;
          cpu_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Scoreboard bench for text_buffer_arbiter: stimulus queues expected RAM writes/acks, a monitor pops and compares.
module tb_text_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_req = 1'b0;
  logic [1:0] kbd_op = 2'b00;
  logic [7:0] kbd_char = 8'h00;
  logic       kbd_ack;
  logic       cpu_req = 1'b0;
  logic [1:0] cpu_op = 2'b00;
  logic [7:0] cpu_char = 8'h00;
  logic       cpu_ack;
  logic       ram_we;
  logic [9:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [9:0] cursor;
  logic       busy;

  text_buffer_arbiter dut (
    .clk(clk), .rst(rst),
    .kbd_req(kbd_req), .kbd_op(kbd_op), .kbd_char(kbd_char), .kbd_ack(kbd_ack),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_char(cpu_char), .cpu_ack(cpu_ack),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic [7:0] data;
    logic       k;
    logic       c;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic push(input logic we, input logic [9:0] addr, input logic [7:0] data,
                      input logic k, input logic c);
    ev_t e;
    e.we = we; e.addr = addr; e.data = data; e.k = k; e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a write or an ack must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ram_we || kbd_ack || cpu_ack)) begin
        check("ack_exclusive", int'(kbd_ack && cpu_ack), 0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: got we=%0d addr=%0d data=%0d kack=%0d cack=%0d expected none",
                   ram_we, ram_waddr, ram_wdata, kbd_ack, cpu_ack);
        end else begin
          e = exp_q.pop_front();
          check("ev_we", int'(ram_we), int'(e.we));
          check("ev_kbd_ack", int'(kbd_ack), int'(e.k));
          check("ev_cpu_ack", int'(cpu_ack), int'(e.c));
          if (e.we) begin
            check("ev_addr", int'(ram_waddr), int'(e.addr));
            check("ev_data", int'(ram_wdata), int'(e.data));
          end
        end
      end
    end
  end

  task automatic wait_ack(input bit from_cpu, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(from_cpu ? cpu_ack : kbd_ack) && n < 1200);
    if (n >= 1200) begin
      checks++;
      $display("FAIL %s_timeout: got no ack expected ack within 1200 cycles", name);
    end else begin
      check({name, "_busy"}, int'(busy), 1);
    end
  endtask

  // Issue one command at a negedge, hold req until ack, then let the cursor settle.
  task automatic cmd(input bit from_cpu, input logic [1:0] op, input logic [7:0] ch);
    $display("cmd src=%s op=%0d char=%02h cursor=%0d", from_cpu ? "cpu" : "kbd", op, ch, cursor);
    if (from_cpu) begin cpu_req = 1'b1; cpu_op = op; cpu_char = ch; end
    else          begin kbd_req = 1'b1; kbd_op = op; kbd_char = ch; end
    wait_ack(from_cpu, from_cpu ? "cpu_cmd" : "kbd_cmd");
    if (from_cpu) cpu_req = 1'b0;
    else          kbd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic put(input bit from_cpu, input logic [7:0] ch, input logic [9:0] addr);
    push(1'b1, addr, ch, !from_cpu, from_cpu);
    cmd(from_cpu, 2'b00, ch);
  endtask

  task automatic nl(input bit from_cpu);
    push(1'b0, 10'd0, 8'h00, !from_cpu, from_cpu);
    cmd(from_cpu, 2'b01, 8'h00);
  endtask

  task automatic bs(input bit from_cpu, input logic wr, input logic [9:0] addr);
    push(wr, addr, 8'h00, !from_cpu, from_cpu);
    cmd(from_cpu, 2'b10, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_cursor", int'(cursor), 0);
    check("rst_we", int'(ram_we), 0);
    check("rst_waddr", int'(ram_waddr), 0);
    check("rst_wdata", int'(ram_wdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_acks", int'({kbd_ack, cpu_ack}), 0);

    // 1: first put char
    put(1'b0, 8'h0A, 10'd0);
    check("t1_cursor", int'(cursor), 1);

    // 2: simultaneous requests, keyboard first after reset
    do_reset();
    push(1'b1, 10'd0, 8'h11, 1'b1, 1'b0);
    push(1'b1, 10'd1, 8'h22, 1'b0, 1'b1);
    $display("cmd tie kbd=11 cpu=22 cursor=%0d", cursor);
    kbd_req = 1'b1; kbd_op = 2'b00; kbd_char = 8'h11;
    cpu_req = 1'b1; cpu_op = 2'b00; cpu_char = 8'h22;
    wait_ack(1'b0, "t2_kbd");
    kbd_req = 1'b0;
    wait_ack(1'b1, "t2_cpu");
    cpu_req = 1'b0;
    @(negedge clk);
    check("t2_cursor", int'(cursor), 2);

    // 3: newline from 5, then wrap from line 15
    put(1'b0, 8'h41, 10'd2);
    put(1'b0, 8'h42, 10'd3);
    put(1'b0, 8'h43, 10'd4);
    check("t3_cursor5", int'(cursor), 5);
    nl(1'b1);
    check("t3_nl_64", int'(cursor), 64);
    for (int i = 0; i < 14; i++) nl(1'b1);
    check("t3_nl_960", int'(cursor), 960);
    for (int i = 0; i < 40; i++) put(1'b0, 8'h61, 10'(960 + i));
    check("t3_cursor1000", int'(cursor), 1000);
    nl(1'b1);
    check("t3_nl_wrap", int'(cursor), 0);

    // 4: backspace across a line start
    nl(1'b0);
    check("t4_cursor64", int'(cursor), 64);
`ifdef TB_ARB_BS_GUARD_EN
    bs(1'b0, 1'b0, 10'd0);
    check("t4_bs_guard", int'(cursor), 64);
`else
    bs(1'b0, 1'b1, 10'd63);
    check("t4_bs", int'(cursor), 63);
`endif

    // 5: clear while the CPU waits
    do_reset();
    nl(1'b0); nl(1'b0); nl(1'b0);
    for (int i = 0; i < 8; i++) put(1'b0, 8'h70, 10'(192 + i));
    check("t5_cursor200", int'(cursor), 200);
    for (int a = 0; a < 1024; a++) push(1'b1, 10'(a), 8'h00, a == 1023, 1'b0);
    push(1'b1, 10'd0, 8'h55, 1'b0, 1'b1);
    $display("cmd src=kbd op=3 (clear) with cpu put 55 pending cursor=%0d", cursor);
    kbd_req = 1'b1; kbd_op = 2'b11; kbd_char = 8'h00;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = 2'b00; cpu_char = 8'h55;
    check("t5_busy_clear", int'(busy), 1);
    wait_ack(1'b0, "t5_clear");
    kbd_req = 1'b0;
    @(negedge clk);
    check("t5_cursor_after_clear", int'(cursor), 0);
    wait_ack(1'b1, "t5_cpu");
    cpu_req = 1'b0;
    @(negedge clk);
    check("t5_cursor_after_cpu", int'(cursor), 1);
    bs(1'b0, 1'b1, 10'd0);
    check("t5_bs_to0", int'(cursor), 0);
    bs(1'b0, 1'b0, 10'd0);
    check("t5_bs_at0", int'(cursor), 0);

    // 6: put at 1023 wraps, then reset in the middle of a clear
    do_reset();
    for (int i = 0; i < 15; i++) nl(1'b1);
    for (int i = 0; i < 63; i++) put(1'b1, 8'h30, 10'(960 + i));
    check("t6_cursor1023", int'(cursor), 1023);
    put(1'b0, 8'h33, 10'd1023);
    check("t6_wrap", int'(cursor), 0);
    put(1'b0, 8'h44, 10'd0);
    check("t6_cursor1", int'(cursor), 1);
    for (int a = 0; a <= 500; a++) push(1'b1, 10'(a), 8'h00, 1'b0, 1'b0);
    $display("cmd src=kbd op=3 (clear, reset at 500) cursor=%0d", cursor);
    kbd_req = 1'b1; kbd_op = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ram_we && ram_waddr == 10'd500) && n < 1200);
    if (n >= 1200) begin
      checks++;
      $display("FAIL t6_addr500_timeout: got no write at 500 expected one within 1200 cycles");
    end
    #1 rst = 1'b1;
    kbd_req = 1'b0;
    @(negedge clk);
    check("t6_rst_we", int'(ram_we), 0);
    check("t6_rst_cursor", int'(cursor), 0);
    check("t6_rst_ack", int'({kbd_ack, cpu_ack}), 0);
    check("t6_rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
